// File: rtl/lii_out_arbiter.sv
// ---------------------------------------------------------------------------
// lii_out_arbiter
//
// Purpose:
//   Shares one LII phy output channel between N kernel-wrapper output
//   streams. Each requester presents an already-packed PW-bit beat together
//   with its source/destination tags. A round-robin arbiter grants one
//   requester at a time. A grant lasts until the requester has delivered
//   BURST beats or stops presenting data, so no requester can starve the
//   others. The output stage is a single fully registered beat.
//
// Handshake semantics (applies to the req_* side and the lii_out_* side):
//   A beat transfers on a rising aclk edge where valid and ready are both
//   high. A producer holding valid high keeps its payload stable until that
//   edge. Ready may depend combinationally on the consumer's own state. On
//   this block, req_tready[g] depends on lii_out_tvalid and lii_out_tready.
//
// Ports:
//   aclk, arstn                 clock, asynchronous active-low reset
//   req_tdata  [N*PW]           requester i beat at [i*PW +: PW]
//   req_tvalid [N]              requester valid
//   req_tready [N]              requester ready (only the granted one can be 1)
//   req_src    [N*8]            requester i source id at [i*8 +: 8]
//   req_dst    [N*8]            requester i destination id at [i*8 +: 8]
//   lii_out_tdata/src/dst       registered phy output beat and tags
//   lii_out_tvalid              registered phy output valid
//   lii_out_tready              phy output ready
//   grant_idx  [IW]             currently or last granted requester
//   busy                        high while in GRANT
//   o_dbg_state                 FSM state (0 = IDLE, 1 = GRANT)
//   o_dbg_rr_ptr [IW]           round-robin search start for the next pick
// ---------------------------------------------------------------------------
module lii_out_arbiter #(
  parameter int N     = 4,
  parameter int PW    = 64,
  parameter int BURST = 4,
  parameter int IW    = $clog2(N)
) (
  input  logic              aclk,
  input  logic              arstn,
  input  logic [N*PW-1:0]   req_tdata,
  input  logic [N-1:0]      req_tvalid,
  output logic [N-1:0]      req_tready,
  input  logic [N*8-1:0]    req_src,
  input  logic [N*8-1:0]    req_dst,
  output logic [PW-1:0]     lii_out_tdata,
  output logic              lii_out_tvalid,
  input  logic              lii_out_tready,
  output logic [7:0]        lii_out_src,
  output logic [7:0]        lii_out_dst,
  output logic [IW-1:0]     grant_idx,
  output logic              busy,
  output logic              o_dbg_state,
  output logic [IW-1:0]     o_dbg_rr_ptr
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Beat counter is 8 bits wide because BURST is at most 255.
  localparam logic [7:0] BURST_LAST = 8'(BURST - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IW-1:0]     r_grant_idx;
  logic [IW-1:0]     r_rr_ptr;
  logic [7:0]        r_beat_cnt;

  logic              r_out_valid;
  logic [PW-1:0]     r_out_data;
  logic [7:0]        r_out_src;
  logic [7:0]        r_out_dst;

  logic [2*N-1:0]    w_req_dbl;
  logic [N-1:0]      w_req_rot;
  logic              w_pick_vld;
  logic [IW-1:0]     w_pick_ofs;
  logic [IW:0]       w_pick_sum;
  logic [IW-1:0]     w_pick_idx;

  logic              w_out_free;
  logic              w_accept;
  logic              w_release;
  logic [IW-1:0]     w_next_rr;
  logic [N-1:0]      w_req_tready;

  logic [PW-1:0]     w_sel_data;
  logic [7:0]        w_sel_src;
  logic [7:0]        w_sel_dst;
  logic              w_sel_valid;

  // -------------------------------------------------------------------------
  // Round-robin pick.
  // Rotate the valid vector so that bit 0 is requester rr_ptr. The first set
  // bit then gives the offset from rr_ptr. Doubling the vector lets a plain
  // right shift perform the rotation.
  // -------------------------------------------------------------------------
  assign w_req_dbl = {req_tvalid, req_tvalid};
  assign w_req_rot = w_req_dbl[N-1:0] | '0;

  logic [2*N-1:0] w_req_shift;
  assign w_req_shift = w_req_dbl >> r_rr_ptr;

  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_ofs = '0;
    // Scan from the highest offset down so the lowest set offset wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (w_req_shift[k]) begin
        w_pick_vld = 1'b1;
        w_pick_ofs = IW'(k);
      end
    end
  end

  // Convert the offset back to an absolute index: (rr_ptr + ofs) mod N.
  always_comb begin
    w_pick_sum = {1'b0, r_rr_ptr} + {1'b0, w_pick_ofs};
    if (w_pick_sum >= (IW+1)'(N)) begin
      w_pick_sum = w_pick_sum - (IW+1)'(N);
    end
    w_pick_idx = w_pick_sum[IW-1:0];
  end

  // Next search start after releasing grant g is (g + 1) mod N.
  assign w_next_rr = (r_grant_idx == IW'(N - 1)) ? '0 : r_grant_idx + 1'b1;

  // -------------------------------------------------------------------------
  // Granted requester's payload.
  // -------------------------------------------------------------------------
  assign w_sel_data  = req_tdata[r_grant_idx*PW +: PW];
  assign w_sel_src   = req_src[r_grant_idx*8 +: 8];
  assign w_sel_dst   = req_dst[r_grant_idx*8 +: 8];
  assign w_sel_valid = req_tvalid[r_grant_idx];

  // The output register can take a new beat when it is empty or drains now.
  assign w_out_free = !r_out_valid || lii_out_tready;

  // -------------------------------------------------------------------------
  // FSM: next state and grant-side handshake.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_req_tready = '0;
    w_accept     = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // IDLE always lasts one cycle per arbitration. This cycle is the
        // bubble between grants.
        if (w_pick_vld) begin
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        w_req_tready[r_grant_idx] = w_out_free;
        w_accept = w_sel_valid && w_out_free;
        // Release when the burst ends on this accept, or when the granted
        // requester has nothing to offer this cycle.
        if (w_accept && (r_beat_cnt == BURST_LAST)) begin
          w_release = 1'b1;
        end else if (!w_sel_valid) begin
          w_release = 1'b1;
        end
        if (w_release) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Grant index, round-robin pointer, beat counter.
  // -------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
      r_beat_cnt  <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_pick_vld) begin
        r_grant_idx <= w_pick_idx;
        r_beat_cnt  <= '0;
      end
      // Saturate at BURST-1. The count is never compared beyond that value.
      if (w_accept && (r_beat_cnt != BURST_LAST)) begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
      end
      if (w_release) begin
        r_rr_ptr <= w_next_rr;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output register. A new accept overwrites a beat draining this cycle.
  // Otherwise, a drained beat clears valid and a stalled beat holds.
  // -------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_out_dst   <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_src   <= w_sel_src;
        r_out_dst   <= w_sel_dst;
      end else if (r_out_valid && lii_out_tready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs.
  // -------------------------------------------------------------------------
  assign req_tready     = w_req_tready;
  assign lii_out_tdata  = r_out_data;
  assign lii_out_tvalid = r_out_valid;
  assign lii_out_src    = r_out_src;
  assign lii_out_dst    = r_out_dst;
  assign grant_idx      = r_grant_idx;
  assign busy           = (r_state == ST_GRANT);
  assign o_dbg_state    = r_state;
  assign o_dbg_rr_ptr   = r_rr_ptr;

endmodule

// File: tb/tb_lii_out_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lii_out_arbiter
//
// Directed scenarios plus randomized phases for lii_out_arbiter.
//
// Each requester owns a queue of packed beats {src, dst, data}. A requester
// presents the head of its queue while the queue is non-empty and pops the
// head on a handshake. All queues of a phase are loaded at once while the
// arbiter is idle.
//
// The reference model works at transaction level. It walks round-robin over
// the non-empty queues and gives each grant min(BURST, remaining) beats. From
// that walk it produces:
//   - the expected output beat stream,
//   - the expected grant order,
//   - the expected pointer after each release.
// ---------------------------------------------------------------------------
module tb_lii_out_arbiter;

  localparam int N     = 4;
  localparam int PW    = 64;
  localparam int BURST = 4;
  localparam int IW    = $clog2(N);
  localparam int BW    = PW + 16;

  // ---------------- clock / reset ----------------
  logic              aclk;
  logic              arstn;
  logic [N*PW-1:0]   req_tdata;
  logic [N-1:0]      req_tvalid;
  logic [N-1:0]      req_tready;
  logic [N*8-1:0]    req_src;
  logic [N*8-1:0]    req_dst;
  logic [PW-1:0]     lii_out_tdata;
  logic              lii_out_tvalid;
  logic              lii_out_tready;
  logic [7:0]        lii_out_src;
  logic [7:0]        lii_out_dst;
  logic [IW-1:0]     grant_idx;
  logic              busy;
  logic              o_dbg_state;
  logic [IW-1:0]     o_dbg_rr_ptr;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  lii_out_arbiter #(.N(N), .PW(PW), .BURST(BURST), .IW(IW)) dut (
    .aclk           (aclk),
    .arstn          (arstn),
    .req_tdata      (req_tdata),
    .req_tvalid     (req_tvalid),
    .req_tready     (req_tready),
    .req_src        (req_src),
    .req_dst        (req_dst),
    .lii_out_tdata  (lii_out_tdata),
    .lii_out_tvalid (lii_out_tvalid),
    .lii_out_tready (lii_out_tready),
    .lii_out_src    (lii_out_src),
    .lii_out_dst    (lii_out_dst),
    .grant_idx      (grant_idx),
    .busy           (busy),
    .o_dbg_state    (o_dbg_state),
    .o_dbg_rr_ptr   (o_dbg_rr_ptr)
  );

  // ---------------- scoreboard state ----------------
  logic [BW-1:0] rq [N][$];
  logic [BW-1:0] exp_q[$];
  int            exp_grants[$];
  int            exp_rr[$];
  int            grant_log[$];
  int            rr_log[$];
  int            rise_log[$];
  int            fall_log[$];
  int            xfer_log[$];
  int            rr_model;
  int            cyc;
  logic          prev_busy;
  logic          rand_ready;
  int            n_checks;
  int            n_pass;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        req_tvalid[i] = 1'b1;
        {req_src[i*8 +: 8], req_dst[i*8 +: 8], req_tdata[i*PW +: PW]} = rq[i][0];
      end else begin
        req_tvalid[i] = 1'b0;
      end
    end
  endtask

  task automatic push_beats(input int i, input int n);
    logic [BW-1:0] b;
    for (int k = 0; k < n; k++) begin
      b = {8'($urandom), 8'($urandom), $urandom, $urandom};
      rq[i].push_back(b);
    end
  endtask

  // One clock cycle.
  // At the falling edge: sample the handshakes and check output transfers.
  // 1 time unit after the rising edge: update the requester drivers.
  task automatic tick();
    logic [N-1:0] acc;
    @(negedge aclk);
    acc = req_tvalid & req_tready;
    if (lii_out_tvalid && lii_out_tready) begin
      xfer_log.push_back(cyc);
      if (exp_q.size() == 0) check("extra_beat", 96'(lii_out_tdata), 96'hx_dead);
      else check("out_beat", {16'h0, lii_out_src, lii_out_dst, lii_out_tdata}, {16'h0, exp_q.pop_front()});
    end
    if (busy && !prev_busy) begin
      grant_log.push_back(int'(grant_idx));
      rise_log.push_back(cyc);
    end
    if (!busy && prev_busy) begin
      fall_log.push_back(cyc);
      rr_log.push_back(int'(o_dbg_rr_ptr));
    end
    prev_busy = busy;
    @(posedge aclk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    end
    if (rand_ready) lii_out_tready = ($urandom_range(0, 3) != 0);
    drive_reqs();
  endtask

  // ---------------- reference model ----------------
  task automatic model_phase();
    int pos[N];
    int p;
    int g;
    int take;
    for (int i = 0; i < N; i++) pos[i] = 0;
    p = rr_model;
    while (1) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (p + k) % N;
        if (g < 0 && pos[j] < rq[j].size()) g = j;
      end
      if (g < 0) break;
      take = rq[g].size() - pos[g];
      if (take > BURST) take = BURST;
      for (int k = 0; k < take; k++) exp_q.push_back(rq[g][pos[g] + k]);
      pos[g] += take;
      exp_grants.push_back(g);
      exp_rr.push_back((g + 1) % N);
      p = (g + 1) % N;
    end
    rr_model = p;
  endtask

  task automatic start_phase();
    grant_log.delete(); rr_log.delete(); rise_log.delete(); fall_log.delete();
    xfer_log.delete(); exp_grants.delete(); exp_rr.delete();
    cyc = 0;
    model_phase();
    drive_reqs();
  endtask

  task automatic finish_phase(input string name);
    logic done;
    done = 1'b0;
    for (int t = 0; t < 600 && !done; t++) begin
      tick();
      done = !lii_out_tvalid && !busy && (exp_q.size() == 0);
      for (int i = 0; i < N; i++) if (rq[i].size() != 0) done = 1'b0;
    end
    tick();
    check({name, "_drain"}, 96'(done), 96'd1);
    check({name, "_ngrants"}, 96'(grant_log.size()), 96'(exp_grants.size()));
    for (int k = 0; k < grant_log.size() && k < exp_grants.size(); k++)
      check({name, "_grant"}, 96'(grant_log[k]), 96'(exp_grants[k]));
    check({name, "_nrel"}, 96'(rr_log.size()), 96'(exp_rr.size()));
    for (int k = 0; k < rr_log.size() && k < exp_rr.size(); k++)
      check({name, "_rr"}, 96'(rr_log[k]), 96'(exp_rr[k]));
    for (int k = 1; k < rise_log.size() && k <= fall_log.size(); k++)
      check({name, "_gap"}, 96'(rise_log[k] - fall_log[k-1]), 96'd1);
    check({name, "_rr_end"}, 96'(o_dbg_rr_ptr), 96'(rr_model));
  endtask

  task automatic run_phase(input string name);
    start_phase();
    finish_phase(name);
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_tvalid"}, 96'(lii_out_tvalid), 96'd0);
    check({p, "_tdata"},  96'(lii_out_tdata), 96'd0);
    check({p, "_src"},    96'(lii_out_src), 96'd0);
    check({p, "_dst"},    96'(lii_out_dst), 96'd0);
    check({p, "_tready"}, 96'(req_tready), 96'd0);
    check({p, "_gidx"},   96'(grant_idx), 96'd0);
    check({p, "_busy"},   96'(busy), 96'd0);
    check({p, "_state"},  96'(o_dbg_state), 96'd0);
    check({p, "_rr"},     96'(o_dbg_rr_ptr), 96'd0);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) rq[i].delete();
    exp_q.delete();
    drive_reqs();
  endtask

  task automatic do_reset();
    arstn = 1'b0;
    rand_ready = 1'b0;
    lii_out_tready = 1'b1;
    clear_reqs();
    repeat (2) @(posedge aclk);
    #1;
    arstn = 1'b1;
    rr_model = 0;
    prev_busy = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [BW-1:0] snap;
    int exp_xfer[6];
    n_checks = 0; n_pass = 0; cyc = 0;
    prev_busy = 1'b0; rand_ready = 1'b0; rr_model = 0;
    arstn = 1'b0;
    req_tdata = '0; req_tvalid = '0; req_src = '0; req_dst = '0;
    lii_out_tready = 1'b1;
    #12;
    check_reset_vals("rst0");
    @(posedge aclk);
    #1;
    arstn = 1'b1;

    // 1: req0 alone, 6 beats. The grant breaks after 4 beats, one bubble.
    push_beats(0, 6);
    run_phase("t1");
    exp_xfer = '{2, 3, 4, 5, 7, 8};
    check("t1_nxfer", 96'(xfer_log.size()), 96'd6);
    for (int k = 0; k < 6 && k < xfer_log.size(); k++)
      check("t1_xfer_cyc", 96'(xfer_log[k]), 96'(exp_xfer[k]));
    check("t1_rr", 96'(o_dbg_rr_ptr), 96'd1);

    // 2: all requesters valid. Expected grant order is 0,1,2,3,0.
    do_reset();
    push_beats(0, 8);
    for (int i = 1; i < N; i++) push_beats(i, 4);
    run_phase("t2");
    check("t2_first_grant", 96'(grant_log.size() > 0 ? grant_log[0] : -1), 96'd0);

    // 3: req2 with the output stalled for 5 cycles.
    push_beats(2, 3);
    lii_out_tready = 1'b0;
    start_phase();
    for (int t = 0; t < 10 && !lii_out_tvalid; t++) tick();
    check("t3_first_valid", 96'(lii_out_tvalid), 96'd1);
    snap = {lii_out_src, lii_out_dst, lii_out_tdata};
    for (int t = 0; t < 5; t++) begin
      tick();
      check("t3_hold", {16'h0, lii_out_src, lii_out_dst, lii_out_tdata}, {16'h0, snap});
      check("t3_valid", 96'(lii_out_tvalid), 96'd1);
      check("t3_tready2", 96'(req_tready[2]), 96'd0);
    end
    lii_out_tready = 1'b1;
    finish_phase("t3");

    // 5: pointer at 3 with req0 and req3 valid. Expected order 3 then 0.
    check("t5_rr_pre", 96'(o_dbg_rr_ptr), 96'd3);
    push_beats(0, 2);
    push_beats(3, 2);
    run_phase("t5");
    check("t5_first_grant", 96'(grant_log.size() > 0 ? grant_log[0] : -1), 96'd3);

    // 4: req1 stops after 2 beats. Pointer goes to 2, then req3 is granted.
    push_beats(1, 2);
    push_beats(3, 2);
    run_phase("t4");
    check("t4_rr_after_req1", 96'(rr_log.size() > 0 ? rr_log[0] : -1), 96'd2);

    // 6: reset asserted while the second beat of a burst is on the output.
    push_beats(0, 4);
    start_phase();
    for (int t = 0; t < 10 && xfer_log.size() < 1; t++) tick();
    check("t6_mid_valid", 96'(lii_out_tvalid), 96'd1);
    #2;
    arstn = 1'b0;
    #1;
    check_reset_vals("t6_rst");
    clear_reqs();
    rr_model = 0;
    prev_busy = 1'b0;
    @(posedge aclk);
    #1;
    arstn = 1'b1;
    push_beats(0, 3);
    push_beats(3, 2);
    run_phase("t6_post");
    check("t6_first_grant", 96'(grant_log.size() > 0 ? grant_log[0] : -1), 96'd0);

    // Random phases: random queue depths and random output backpressure.
    for (int r = 0; r < 6; r++) begin
      int tot;
      tot = 0;
      for (int i = 0; i < N; i++) begin
        int n;
        n = $urandom_range(0, 9);
        push_beats(i, n);
        tot += n;
      end
      if (tot == 0) push_beats($urandom_range(0, N - 1), 1);
      rand_ready = 1'b1;
      run_phase("rnd");
      rand_ready = 1'b0;
      lii_out_tready = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
